// File: rtl/clk_gen_pkg.sv
// Shared constants for the SM83 clock/reset generator:
// phase geometry, per-output phase masks and start-up defaults.
package clk_gen_pkg;

  localparam int PH_W   = 3;
  localparam int MC_LEN = 8;

  // bit i set = output high in phase i
  localparam logic [7:0] MASK_MAIN  = 8'h0F;
  localparam logic [7:0] MASK_ADR   = 8'h3C;
  localparam logic [7:0] MASK_INC   = 8'h30;
  localparam logic [7:0] MASK_DATA  = 8'hC3;
  localparam logic [7:0] MASK_LATCH = 8'h80;

  localparam int DEF_STABLE_CYCLES = 16;
  localparam int DEF_RESET_MCYCLES = 4;

endpackage

// File: rtl/osc_stab_timer.sv
// Oscillator stabilisation timer: counts enabled edges and
// raises a sticky stable flag when the count hits STABLE_CYCLES.
module osc_stab_timer
  import clk_gen_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_stable,
  output logic o_stable_d
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_stable;
  logic          w_hit;

  assign w_hit      = i_en && (r_cnt == CW'(STABLE_CYCLES - 1));
  assign o_stable_d = r_stable | w_hit;
  assign o_stable   = r_stable;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      if (i_en && !r_stable)
        r_cnt <= r_cnt + 1'b1;
      r_stable <= o_stable_d;
    end
  end

endmodule

// File: rtl/external_clk.sv
// SM83 clock/reset generator: 8-phase sequencer, gated
// phase-decoded core clocks and reset sequencing.
module external_clk
  import clk_gen_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int RESET_MCYCLES = DEF_RESET_MCYCLES
) (
  input  logic CLK,
  input  logic RESET,
  output logic ADR_CLK_N,
  output logic ADR_CLK_P,
  output logic DATA_CLK_N,
  output logic DATA_CLK_P,
  output logic INC_CLK_N,
  output logic INC_CLK_P,
  output logic LATCH_CLK,
  output logic MAIN_CLK_N,
  output logic MAIN_CLK_P,
  output logic CLK_ENA,
  output logic OSC_ENA,
  output logic OSC_STABLE,
  output logic ASYNC_RESET,
  output logic SYNC_RESET
);

  localparam int MW = $clog2(RESET_MCYCLES + 2);

  logic [PH_W-1:0] r_ph;
  logic [PH_W-1:0] w_ph_nxt;
  logic [MW-1:0]   r_mc;
  logic            w_wrap;
  logic            w_ena_nxt;
  logic            w_stable_d;

  osc_stab_timer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stab (
    .i_clk     (CLK),
    .i_rst_n   (RESET),
    .i_en      (OSC_ENA),
    .o_stable  (OSC_STABLE),
    .o_stable_d(w_stable_d)
  );

  assign w_wrap    = OSC_ENA && (r_ph == PH_W'(MC_LEN - 1));
  assign w_ph_nxt  = OSC_ENA ? r_ph + 1'b1 : r_ph;
  // gate opens only on an M-cycle boundary
  assign w_ena_nxt = CLK_ENA | (w_wrap & OSC_STABLE);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_ph        <= '0;
      r_mc        <= '0;
      OSC_ENA     <= 1'b0;
      CLK_ENA     <= 1'b0;
      ASYNC_RESET <= 1'b1;
      SYNC_RESET  <= 1'b1;
      MAIN_CLK_P  <= 1'b0;
      MAIN_CLK_N  <= 1'b1;
      ADR_CLK_P   <= 1'b0;
      ADR_CLK_N   <= 1'b1;
      INC_CLK_P   <= 1'b0;
      INC_CLK_N   <= 1'b1;
      DATA_CLK_P  <= 1'b0;
      DATA_CLK_N  <= 1'b1;
      LATCH_CLK   <= 1'b0;
    end else begin
      OSC_ENA     <= 1'b1;
      r_ph        <= w_ph_nxt;
      CLK_ENA     <= w_ena_nxt;
      ASYNC_RESET <= ~w_stable_d;
      if (w_wrap && w_ena_nxt) begin
        if (r_mc != MW'(RESET_MCYCLES + 1))
          r_mc <= r_mc + 1'b1;
        if (r_mc == MW'(RESET_MCYCLES))
          SYNC_RESET <= 1'b0;
      end
      MAIN_CLK_P <= w_ena_nxt & MASK_MAIN[w_ph_nxt];
      MAIN_CLK_N <= ~(w_ena_nxt & MASK_MAIN[w_ph_nxt]);
      ADR_CLK_P  <= w_ena_nxt & MASK_ADR[w_ph_nxt];
      ADR_CLK_N  <= ~(w_ena_nxt & MASK_ADR[w_ph_nxt]);
      INC_CLK_P  <= w_ena_nxt & MASK_INC[w_ph_nxt];
      INC_CLK_N  <= ~(w_ena_nxt & MASK_INC[w_ph_nxt]);
      DATA_CLK_P <= w_ena_nxt & MASK_DATA[w_ph_nxt];
      DATA_CLK_N <= ~(w_ena_nxt & MASK_DATA[w_ph_nxt]);
      LATCH_CLK  <= w_ena_nxt & MASK_LATCH[w_ph_nxt];
    end
  end

endmodule

// File: tb/tb_external_clk.sv
// Directed bench for external_clk: default and short start-up
// parameterisations side by side, plus a mid-run reset.
module tb_external_clk;

  logic CLK = 1'b0;
  logic RESET = 1'b0;

  always #5 CLK = ~CLK;

  logic a_adr_n, a_adr_p, a_dat_n, a_dat_p, a_inc_n, a_inc_p;
  logic a_lat, a_main_n, a_main_p, a_ena, a_osc, a_stb, a_ar, a_sr;
  logic b_adr_n, b_adr_p, b_dat_n, b_dat_p, b_inc_n, b_inc_p;
  logic b_lat, b_main_n, b_main_p, b_ena, b_osc, b_stb, b_ar, b_sr;

  external_clk u_a (
    .CLK(CLK), .RESET(RESET),
    .ADR_CLK_N(a_adr_n), .ADR_CLK_P(a_adr_p),
    .DATA_CLK_N(a_dat_n), .DATA_CLK_P(a_dat_p),
    .INC_CLK_N(a_inc_n), .INC_CLK_P(a_inc_p),
    .LATCH_CLK(a_lat),
    .MAIN_CLK_N(a_main_n), .MAIN_CLK_P(a_main_p),
    .CLK_ENA(a_ena), .OSC_ENA(a_osc), .OSC_STABLE(a_stb),
    .ASYNC_RESET(a_ar), .SYNC_RESET(a_sr)
  );

  external_clk #(
    .STABLE_CYCLES(3),
    .RESET_MCYCLES(1)
  ) u_b (
    .CLK(CLK), .RESET(RESET),
    .ADR_CLK_N(b_adr_n), .ADR_CLK_P(b_adr_p),
    .DATA_CLK_N(b_dat_n), .DATA_CLK_P(b_dat_p),
    .INC_CLK_N(b_inc_n), .INC_CLK_P(b_inc_p),
    .LATCH_CLK(b_lat),
    .MAIN_CLK_N(b_main_n), .MAIN_CLK_P(b_main_p),
    .CLK_ENA(b_ena), .OSC_ENA(b_osc), .OSC_STABLE(b_stb),
    .ASYNC_RESET(b_ar), .SYNC_RESET(b_sr)
  );

  // ph order: bit i = phase i
  localparam logic [7:0] P_MAIN  = 8'b0000_1111;
  localparam logic [7:0] P_ADR   = 8'b0011_1100;
  localparam logic [7:0] P_INC   = 8'b0011_0000;
  localparam logic [7:0] P_DATA  = 8'b1100_0011;
  localparam logic [7:0] P_LATCH = 8'b1000_0000;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [13:0] got,
                     input logic [13:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // {osc,stb,ena,async,sync,mp,mn,ap,an,ip,in,dp,dn,latch}
  function automatic logic [13:0] expv(int n, int e_stb,
                                       int e_ena, int e_sr);
    logic [2:0] ph;
    logic on, mp, ap, ip, dp, lp;
    if (n == 0)
      return 14'b0_0_0_1_1_01_01_01_01_0;
    ph = 3'((n - 1) % 8);
    on = (n >= e_ena);
    mp = on & P_MAIN[ph];
    ap = on & P_ADR[ph];
    ip = on & P_INC[ph];
    dp = on & P_DATA[ph];
    lp = on & P_LATCH[ph];
    return {1'b1, 1'(n >= e_stb), on, 1'(n < e_stb),
            1'(n < e_sr), mp, ~mp, ap, ~ap,
            ip, ~ip, dp, ~dp, lp};
  endfunction

  function automatic logic [13:0] va();
    return {a_osc, a_stb, a_ena, a_ar, a_sr,
            a_main_p, a_main_n, a_adr_p, a_adr_n,
            a_inc_p, a_inc_n, a_dat_p, a_dat_n, a_lat};
  endfunction

  function automatic logic [13:0] vb();
    return {b_osc, b_stb, b_ena, b_ar, b_sr,
            b_main_p, b_main_n, b_adr_p, b_adr_n,
            b_inc_p, b_inc_n, b_dat_p, b_dat_n, b_lat};
  endfunction

  task automatic edge_chk(input string ph, input int n);
    @(posedge CLK);
    #1;
    chk($sformatf("%s_A_e%0d", ph, n), va(), expv(n, 17, 25, 57));
    chk($sformatf("%s_B_e%0d", ph, n), vb(), expv(n, 4, 9, 17));
  endtask

  initial begin
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) edge_chk("rst", 0);

    RESET = 1'b1;
    for (int n = 1; n <= 100; n++) edge_chk("run1", n);

    RESET = 1'b0;
    for (int i = 0; i < 3; i++) edge_chk("rst2", 0);

    RESET = 1'b1;
    for (int n = 1; n <= 39; n++) edge_chk("run2", n);
    // edge 40 lands mid M-cycle with clocks running
    RESET = 1'b0;
    edge_chk("mid", 0);
    edge_chk("mid", 0);

    RESET = 1'b1;
    for (int n = 1; n <= 100; n++) edge_chk("run3", n);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
